// File: rtl/histogram_result_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | histogram_result_sink: captures one histogram frame from a ready/valid   |
// | stream into a bin register file for random-access readout. Rev 1.0       |
// +--------------------------------------------------------------------------+
module histogram_result_sink #(
  parameter  int P_DW      = 4,
  parameter  int P_NUM_BIN = 8,
  localparam int AW        = $clog2(P_NUM_BIN)
) (
  input  logic            aclk,
  input  logic            areset_n,
  input  logic            arm,
  input  logic [P_DW-1:0] tdata,
  input  logic            tvalid,
  input  logic            tlast,
  output logic            tready,
  input  logic [AW-1:0]   rd_addr,
  output logic [P_DW-1:0] rd_data,
  output logic [AW:0]     bin_cnt,
  output logic            done,
  output logic            len_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_tready;
  logic            r_done;
  logic            r_len_err;
  logic [AW:0]     r_bin_cnt;
  logic [P_DW-1:0] r_rd_data;
  logic [P_DW-1:0] r_bins [P_NUM_BIN];

  logic w_beat;
  logic w_room;
  logic w_len_ok;

  assign w_beat   = tvalid & r_tready;
  assign w_room   = 32'(r_bin_cnt) < P_NUM_BIN;
  // Length check counts the tlast beat itself, so a saturated counter reads as long.
  assign w_len_ok = (32'(r_bin_cnt) + 32'd1) == P_NUM_BIN;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state   <= S_IDLE;
      r_tready  <= 1'b0;
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
      r_bin_cnt <= '0;
      for (int i = 0; i < P_NUM_BIN; i++) r_bins[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state  <= S_CAPTURE;
            r_tready <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (w_beat) begin
            if (w_room) begin
              r_bins[r_bin_cnt[AW-1:0]] <= tdata;
              r_bin_cnt                 <= r_bin_cnt + (AW+1)'(1);
            end else begin
              r_len_err <= 1'b1;
            end
            if (tlast) begin
              r_state  <= S_DONE;
              r_tready <= 1'b0;
              r_done   <= 1'b1;
              if (!w_len_ok) r_len_err <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (arm) begin
            r_state   <= S_CAPTURE;
            r_tready  <= 1'b1;
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
            r_bin_cnt <= '0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tready <= 1'b0;
        end
      endcase
    end
  end

  // Reads see the pre-edge bin contents, so a same-cycle write returns the old value.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_rd_data <= '0;
    end else if (32'(rd_addr) < P_NUM_BIN) begin
      r_rd_data <= r_bins[rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign tready  = r_tready;
  assign done    = r_done;
  assign len_err = r_len_err;
  assign bin_cnt = r_bin_cnt;
  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_histogram_result_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_histogram_result_sink: directed frames checked against a frame-level  |
// | model every cycle, plus literal readouts. Rev 1.0                        |
// +--------------------------------------------------------------------------+
module tb_histogram_result_sink;

  localparam int N  = 8;
  localparam int DW = 4;

  logic          aclk     = 1'b0;
  logic          areset_n = 1'b0;
  logic          arm      = 1'b0;
  logic [DW-1:0] tdata    = '0;
  logic          tvalid   = 1'b0;
  logic          tlast    = 1'b0;
  logic          tready;
  logic [2:0]    rd_addr  = '0;
  logic [DW-1:0] rd_data;
  logic [3:0]    bin_cnt;
  logic          done;
  logic          len_err;

  histogram_result_sink #(.P_DW(DW), .P_NUM_BIN(N)) dut (
    .aclk(aclk), .areset_n(areset_n), .arm(arm), .tdata(tdata),
    .tvalid(tvalid), .tlast(tlast), .tready(tready), .rd_addr(rd_addr),
    .rd_data(rd_data), .bin_cnt(bin_cnt), .done(done), .len_err(len_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: the accepted beats of the current frame, plus the bin image.
  logic [DW-1:0] m_frame[$];
  logic [DW-1:0] m_bins [N];
  bit            m_cap  = 0;
  bit            m_done = 0;
  logic [DW-1:0] m_rd   = '0;
  bit            cmp_en = 0;
  bit            sweep  = 0;

  always @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      m_frame.delete();
      for (int i = 0; i < N; i++) m_bins[i] = '0;
      m_cap = 0; m_done = 0; m_rd = '0;
    end else begin
      m_rd = (int'(rd_addr) < N) ? m_bins[rd_addr] : '0;
      if (m_cap) begin
        if (tvalid) begin
          m_frame.push_back(tdata);
          if (m_frame.size() <= N) m_bins[m_frame.size()-1] = tdata;
          if (tlast) begin m_cap = 0; m_done = 1; end
        end
      end else if (arm) begin
        m_cap = 1; m_done = 0; m_frame.delete();
      end
    end
  end

  always @(negedge aclk) begin
    if (cmp_en) begin
      int sz;
      sz = m_frame.size();
      chk("tready",  32'(tready),  32'(m_cap));
      chk("done",    32'(done),    32'(m_done));
      chk("len_err", 32'(len_err), 32'((sz > N) || (m_done && sz != N)));
      chk("bin_cnt", 32'(bin_cnt), 32'((sz > N) ? N : sz));
      chk("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (sweep) rd_addr = rd_addr + 3'd1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  // Sends n beats starting at 'first' stepping by 'step'; gaps gives 2-on/2-off tvalid.
  task automatic send(input int n, input int first, input int step, input bit gaps);
    int v;
    v = first;
    for (int b = 0; b < n; b++) begin
      bit acc;
      int guard;
      tvalid = 1'b1; tdata = DW'(v); tlast = (b == n-1);
      acc = 0; guard = 0;
      while (!acc) begin
        acc = tready;
        tick();
        guard++;
        if (!acc && guard > 50) begin
          errors++; checks++;
          $display("FAIL beat_timeout got tready=0 expected tready=1 beat %0d", b);
          acc = 1;
        end
      end
      v += step;
      if (gaps && (b % 2 == 1) && b != n-1) begin
        tvalid = 1'b0; tick(); tick();
      end
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic readout(input string name, input logic [DW-1:0] exp [N]);
    bit s;
    s = sweep; sweep = 0;
    for (int i = 0; i < N; i++) begin
      rd_addr = 3'(i);
      tick();
      chk(name, 32'(rd_data), 32'(exp[i]));
    end
    sweep = s;
  endtask

  logic [DW-1:0] e [N];

  initial begin
    repeat (3) tick();
    areset_n = 1'b1;
    cmp_en   = 1;
    sweep    = 1;
    chk("reset_tready", 32'(tready), 32'd0);
    chk("reset_bincnt", 32'(bin_cnt), 32'd0);

    // 1: full frame 1..8, continuous valid
    pulse_arm();
    send(8, 1, 1, 0);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_len_err", 32'(len_err), 32'd0);
    chk("t1_bin_cnt", 32'(bin_cnt), 32'd8);
    e = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    readout("t1_bins", e);

    // 2: valid rises 5 cycles before arm, then 2-on/2-off gaps
    tvalid = 1'b1; tdata = 4'd1;
    repeat (5) tick();
    pulse_arm();
    send(8, 1, 1, 1);
    tick();
    chk("t2_bin_cnt", 32'(bin_cnt), 32'd8);
    readout("t2_bins", e);

    // 3: short frame of 5 beats 9..13; bins 5..7 keep 6,7,8
    pulse_arm();
    send(5, 9, 1, 0);
    tick();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_len_err", 32'(len_err), 32'd1);
    chk("t3_bin_cnt", 32'(bin_cnt), 32'd5);
    e = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd6, 4'd7, 4'd8};
    readout("t3_bins", e);

    // 4: long frame of 10 beats 1..10
    pulse_arm();
    send(10, 1, 1, 0);
    chk("t4_tready_after_last", 32'(tready), 32'd0);
    chk("t4_len_err", 32'(len_err), 32'd1);
    chk("t4_bin_cnt", 32'(bin_cnt), 32'd8);
    e = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    readout("t4_bins", e);

    // 5: reset after 3 beats, then a clean frame 2,3,..,9
    pulse_arm();
    send(3, 5, 1, 0);
    areset_n = 1'b0;
    tick(); tick();
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_bincnt", 32'(bin_cnt), 32'd0);
    chk("t5_rst_rd", 32'(rd_data), 32'd0);
    areset_n = 1'b1;
    e = '{default: 4'd0};
    readout("t5_cleared", e);
    pulse_arm();
    send(8, 2, 1, 0);
    chk("t5_len_err", 32'(len_err), 32'd0);
    chk("t5_done", 32'(done), 32'd1);

    // 6: arm in the DONE cycle right after tlast, frame 8..1
    pulse_arm();
    chk("t6_done_cleared", 32'(done), 32'd0);
    chk("t6_tready", 32'(tready), 32'd1);
    send(8, 8, -1, 0);
    tick();
    chk("t6_len_err", 32'(len_err), 32'd0);
    e = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    readout("t6_bins", e);

    repeat (3) tick();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
